// File: rtl/cache_wb_pkg.sv
// Shared widths, drain-state encoding and buffer-entry layout for the cache write-back buffer.
package cache_wb_pkg;

  localparam int DATA_W  = 10;
  localparam int ADDR_W  = 10;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = 5;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match_cam.sv
// Youngest-match address CAM over the ring, ages counted from rd_ptr; purely combinational, no backpressure.
// skip_head masks the oldest slot so the entry currently being written to memory is never selected.
module wb_match_cam
  import cache_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic                         skip_head,
  input  logic [ADDR_W-1:0]            probe_addr,
  output logic                         hit,
  output logic [PTR_W-1:0]             hit_idx
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (addrs[i] == probe_addr);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[rd_ptr + PTR_W'(k)] && !(skip_head && (k == 0))) begin
        hit     = 1'b1;
        hit_idx = rd_ptr + PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Coalescing write-back FIFO between cache and memory; accept-to-mem_req 2 edges, one IDLE bubble per write.
// evict_ready drops when full or while a flush is pending; lookup is combinational over buffered lines.
module cache_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cache_wb_pkg::DATA_W,
  parameter int ADDR_W = cache_wb_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic [ADDR_W-1:0]        evict_addr,
  input  logic [DATA_W-1:0]        evict_data,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  import cache_wb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  wb_state_e                   state_q, state_d;
  logic      [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic      [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic      [CNT_W-1:0]       count_q, count_d;
  logic                        flush_pending_q, flush_pending_d;
  wb_entry_t [DEPTH-1:0]       entry_q, entry_d;

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic                         co_hit, lu_hit;
  logic [PTR_W-1:0]             co_idx, lu_idx;
  logic                         accept, append, pop;

  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entry_q[i].valid;
      ent_addr[i]  = entry_q[i].addr;
    end
  end

  // Coalescing probe: the head is off limits only while it is on the memory bus.
  wb_match_cam #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_coalesce_cam (
    .valid      (ent_valid),
    .addrs      (ent_addr),
    .rd_ptr     (rd_ptr_q),
    .skip_head  (mem_req),
    .probe_addr (evict_addr),
    .hit        (co_hit),
    .hit_idx    (co_idx)
  );

  wb_match_cam #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup_cam (
    .valid      (ent_valid),
    .addrs      (ent_addr),
    .rd_ptr     (rd_ptr_q),
    .skip_head  (1'b0),
    .probe_addr (lookup_addr),
    .hit        (lu_hit),
    .hit_idx    (lu_idx)
  );

  assign mem_req     = (state_q == WB_REQ);
  assign mem_addr    = entry_q[rd_ptr_q].addr;
  assign mem_wdata   = entry_q[rd_ptr_q].data;
  assign evict_ready = (count_q < FULL_CNT) && !flush_pending_q;
  assign flush_done  = flush_pending_q && (count_q == '0) && (state_q == WB_IDLE);
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign lookup_hit  = lu_hit;
  assign lookup_data = lu_hit ? entry_q[lu_idx].data : '0;

  assign accept = evict_valid && evict_ready;
  assign append = accept && !co_hit;
  assign pop    = mem_req && mem_ack;

  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    entry_d         = entry_q;
    flush_pending_d = flush_pending_q;

    case (state_q)
      WB_IDLE: if (count_q != '0) state_d = WB_REQ;
      WB_REQ: begin
        if (mem_ack) begin
          state_d                 = WB_IDLE;
          entry_d[rd_ptr_q].valid = 1'b0;
          rd_ptr_d                = rd_ptr_q + PTR_ONE;
        end
      end
      default: state_d = WB_IDLE;
    endcase

    // An append never lands on the popped slot: pop implies count>0, append implies count<DEPTH.
    if (accept) begin
      if (co_hit) begin
        entry_d[co_idx].data = evict_data;
      end else begin
        entry_d[wr_ptr_q].valid = 1'b1;
        entry_d[wr_ptr_q].addr  = evict_addr;
        entry_d[wr_ptr_q].data  = evict_data;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
    end

    count_d = count_q + CNT_W'(append) - CNT_W'(pop);

    if (flush_done) begin
      flush_pending_d = 1'b0;
    end else if (flush) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WB_IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      entry_q         <= '0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
      entry_q         <= entry_d;
    end
  end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer: drain, full/backpressure, coalescing, flush and async reset.
module tb_cache_writeback_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evict_valid;
  logic       evict_ready;
  logic [9:0] evict_addr;
  logic [9:0] evict_data;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic [9:0] mem_wdata;
  logic       mem_ack;
  logic [9:0] lookup_addr;
  logic       lookup_hit;
  logic [9:0] lookup_data;
  logic       flush;
  logic       flush_done;
  logic [2:0] count;
  logic       empty;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int fd_base;

  cache_writeback_buffer #(.DEPTH(4), .DATA_W(10), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evict_valid (evict_valid),
    .evict_ready (evict_ready),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .flush       (flush),
    .flush_done  (flush_done),
    .count       (count),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (flush_done === 1'b1) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] a, input logic [9:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_req), 32'h1);
  endtask

  task automatic drain_one(input string tag, input logic [9:0] a, input logic [9:0] d);
    wait_req({tag, "_req"});
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    mem_ack     = 1'b0;
    lookup_addr = '0;
    flush       = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_ready", 32'(evict_ready), 32'h1);
    chk("rst_flush_done", 32'(flush_done), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single line: mem_req two edges after accept, head held until ack.
    push(10'h012, 10'h3A5);
    chk("t1_count", 32'(count), 32'h1);
    chk("t1_req_early", 32'(mem_req), 32'h0);
    tick();
    chk("t1_req", 32'(mem_req), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h012);
    chk("t1_data", 32'(mem_wdata), 32'h3A5);
    tick();
    tick();
    chk("t1_hold_req", 32'(mem_req), 32'h1);
    chk("t1_hold_data", 32'(mem_wdata), 32'h3A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_count_after", 32'(count), 32'h0);
    chk("t1_empty_after", 32'(empty), 32'h1);
    chk("t1_req_after", 32'(mem_req), 32'h0);

    // Fill to DEPTH, refuse a fifth, reopen after one ack.
    push(10'h100, 10'h001);
    push(10'h104, 10'h002);
    push(10'h108, 10'h003);
    push(10'h10C, 10'h004);
    chk("t2_count_full", 32'(count), 32'h4);
    chk("t2_ready_full", 32'(evict_ready), 32'h0);
    push(10'h110, 10'h005);
    chk("t2_count_5th", 32'(count), 32'h4);
    lookup_addr = 10'h110;
    #1;
    chk("t2_5th_hit", 32'(lookup_hit), 32'h0);
    chk("t2_5th_data", 32'(lookup_data), 32'h0);
    chk("t2_head_addr", 32'(mem_addr), 32'h100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_ready_after", 32'(evict_ready), 32'h1);
    chk("t2_count_after", 32'(count), 32'h3);
    chk("t2_bubble", 32'(mem_req), 32'h0);
    drain_one("t2_d1", 10'h104, 10'h002);
    drain_one("t2_d2", 10'h108, 10'h003);
    drain_one("t2_d3", 10'h10C, 10'h004);
    chk("t2_empty", 32'(empty), 32'h1);

    // Coalesce into a non-head entry while the head is in flight.
    push(10'h020, 10'h111);
    push(10'h040, 10'h055);
    chk("t3_req_inflight", 32'(mem_req), 32'h1);
    push(10'h040, 10'h2AA);
    chk("t3_count", 32'(count), 32'h2);
    lookup_addr = 10'h040;
    #1;
    chk("t3_lookup_hit", 32'(lookup_hit), 32'h1);
    chk("t3_lookup_data", 32'(lookup_data), 32'h2AA);
    drain_one("t3_d1", 10'h020, 10'h111);
    drain_one("t3_d2", 10'h040, 10'h2AA);
    chk("t3_empty", 32'(empty), 32'h1);

    // Same address as the in-flight head appends; lookup picks the youngest.
    push(10'h030, 10'h00F);
    wait_req("t4_req");
    push(10'h030, 10'h0F0);
    chk("t4_count", 32'(count), 32'h2);
    lookup_addr = 10'h030;
    #1;
    chk("t4_lookup_hit", 32'(lookup_hit), 32'h1);
    chk("t4_lookup_data", 32'(lookup_data), 32'h0F0);
    lookup_addr = 10'h031;
    #1;
    chk("t4_miss_hit", 32'(lookup_hit), 32'h0);
    chk("t4_miss_data", 32'(lookup_data), 32'h0);
    lookup_addr = 10'h030;
    drain_one("t4_d1", 10'h030, 10'h00F);
    chk("t4_after_pop1", 32'(lookup_data), 32'h0F0);
    drain_one("t4_d2", 10'h030, 10'h0F0);
    chk("t4_after_pop2_hit", 32'(lookup_hit), 32'h0);

    // Flush on an empty buffer completes one cycle after the pulse.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_empty_flush_done", 32'(flush_done), 32'h1);
    tick();
    chk("t5_empty_flush_clr", 32'(flush_done), 32'h0);

    // Flush with three lines queued: pulse exactly once after the last ack.
    fd_base = fd_cnt;
    push(10'h050, 10'h001);
    push(10'h060, 10'h002);
    push(10'h070, 10'h003);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_ready_flush", 32'(evict_ready), 32'h0);
    push(10'h080, 10'h3FF);
    chk("t5_count_blocked", 32'(count), 32'h3);
    drain_one("t5_d1", 10'h050, 10'h001);
    chk("t5_fd_after1", 32'(flush_done), 32'h0);
    drain_one("t5_d2", 10'h060, 10'h002);
    chk("t5_fd_after2", 32'(flush_done), 32'h0);
    drain_one("t5_d3", 10'h070, 10'h003);
    chk("t5_fd_after3", 32'(flush_done), 32'h1);
    tick();
    chk("t5_fd_clear", 32'(flush_done), 32'h0);
    chk("t5_ready_back", 32'(evict_ready), 32'h1);
    tick();
    tick();
    chk("t5_fd_pulses", 32'(fd_cnt - fd_base), 32'h1);

    // Asynchronous reset mid-handshake, then normal operation.
    push(10'h0A0, 10'h123);
    wait_req("t6_req");
    rst_n = 1'b0;
    #1;
    chk("t6_req_async", 32'(mem_req), 32'h0);
    chk("t6_count_async", 32'(count), 32'h0);
    chk("t6_empty_async", 32'(empty), 32'h1);
    tick();
    rst_n = 1'b1;
    lookup_addr = 10'h0A0;
    #1;
    chk("t6_lookup_gone", 32'(lookup_hit), 32'h0);
    push(10'h0B0, 10'h0CC);
    drain_one("t6_d1", 10'h0B0, 10'h0CC);
    chk("t6_empty_end", 32'(empty), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
